// File: rtl/header_stream_arbiter_if.sv
// Header stream arbiter bundle: per-port Avalon-ST inputs with headers on the
// request side, and the merged stream plus header on the inserter side.
// The master modport is the traffic side: sources and the header inserter.
// The slave modport is the arbiter itself.
interface header_stream_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256,
  parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8)
) ();
  logic [NUM_PORTS-1:0]             in_valid;
  logic [NUM_PORTS-1:0]             in_sop;
  logic [NUM_PORTS-1:0]             in_eop;
  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data;
  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty;
  logic [NUM_PORTS-1:0]             in_ready;
  logic [NUM_PORTS*HEADER_SIZE-1:0] hdr_data;
  logic [NUM_PORTS-1:0]             hdr_vld;
  logic                             out_valid;
  logic                             out_sop;
  logic                             out_eop;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [EMPTY_WIDTH-1:0]           out_empty;
  logic                             out_ready;
  logic [HEADER_SIZE-1:0]           out_hdr_data;
  logic                             out_hdr_vld;
  logic [NUM_PORTS-1:0]             grant;
  logic                             busy;

  modport master (
    output in_valid, in_sop, in_eop, in_data, in_empty, hdr_data, hdr_vld, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_data, out_empty,
           out_hdr_data, out_hdr_vld, grant, busy
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, in_empty, hdr_data, hdr_vld, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_data, out_empty,
           out_hdr_data, out_hdr_vld, grant, busy
  );
endinterface

// File: rtl/header_stream_arbiter.sv
// Header stream arbiter: round-robin, packet-locked selection of one of
// NUM_PORTS Avalon-ST streams (each with a header) toward a header inserter.
// A port requests with a valid sop beat and a valid header; the owner holds
// the output until its eop beat is accepted. The forwarded data path is
// purely combinational once locked.
// Optional feature: define HDR_ARB_PKT_CNT_EN to add per-port 16-bit
// counters of accepted eop beats on output pkt_cnt.
module header_stream_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256,
  parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8)
) (
  input  logic clk,
  input  logic rst_n,
  header_stream_arbiter_if.slave bus
`ifdef HDR_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0] pkt_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic                 busy_q;
  logic [IDX_W-1:0]     lastGrant_q;
  logic [IDX_W-1:0]     ownerIdx_q;

  logic [NUM_PORTS-1:0] request;
  logic                 anyRequest;
  logic [IDX_W-1:0]     pick_d;
  logic                 ownerValid;
  logic                 ownerEop;
  logic                 acceptEop;

  assign request    = bus.hdr_vld & bus.in_valid & bus.in_sop;
  assign anyRequest = |request;

  // Round-robin pick: first requesting port after the last owner, wrapping.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] candIdx;
    int               cand;
    found   = 1'b0;
    pick_d  = '0;
    candIdx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(lastGrant_q) + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      candIdx = IDX_W'(cand);
      if (!found && request[candIdx]) begin
        found  = 1'b1;
        pick_d = candIdx;
      end
    end
  end

  assign ownerValid = bus.in_valid[ownerIdx_q];
  assign ownerEop   = bus.in_eop[ownerIdx_q];
  assign acceptEop  = (state_q == LOCK) && ownerValid && bus.out_ready && ownerEop;

  // Packet-lock FSM: grab a port in IDLE, hold it until its eop is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      lastGrant_q <= IDX_W'(NUM_PORTS - 1);
      ownerIdx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyRequest) begin
            state_q    <= LOCK;
            grant_q    <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_d;
            busy_q     <= 1'b1;
            ownerIdx_q <= pick_d;
          end
        end
        LOCK: begin
          if (acceptEop) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            lastGrant_q <= ownerIdx_q;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Locked data path: steer the owner's beat and header straight through.
  always_comb begin
    bus.in_ready     = '0;
    bus.out_valid    = 1'b0;
    bus.out_sop      = 1'b0;
    bus.out_eop      = 1'b0;
    bus.out_data     = '0;
    bus.out_empty    = '0;
    bus.out_hdr_data = '0;
    bus.out_hdr_vld  = 1'b0;
    if (busy_q) begin
      bus.out_hdr_vld = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (ownerIdx_q == IDX_W'(i)) begin
          bus.in_ready[i]  = bus.out_ready;
          bus.out_valid    = bus.in_valid[i];
          bus.out_sop      = bus.in_sop[i];
          bus.out_eop      = bus.in_eop[i];
          bus.out_data     = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
          bus.out_empty    = bus.in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
          bus.out_hdr_data = bus.hdr_data[i*HEADER_SIZE +: HEADER_SIZE];
        end
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

`ifdef HDR_ARB_PKT_CNT_EN
  logic [NUM_PORTS-1:0][15:0] pktCnt_q;

  // Per-port count of accepted eop beats, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pktCnt_q <= '0;
    end else if (acceptEop) begin
      pktCnt_q[ownerIdx_q] <= pktCnt_q[ownerIdx_q] + 16'd1;
    end
  end

  assign pkt_cnt = pktCnt_q;
`endif

endmodule

// File: doc/header_stream_arbiter.md
HEADER_STREAM_ARBITER -- requirements
Module: header_stream_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of requesting streams (2..16).
REQ-002 Parameter DATA_WIDTH, default 128, beat width in bits.
REQ-003 Parameter HEADER_SIZE, default 256, per-port header width; an integer multiple of DATA_WIDTH.
REQ-004 Parameter EMPTY_WIDTH, default $clog2(DATA_WIDTH/8), empty field width.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 in_valid, in_sop, in_eop  in  NUM_PORTS  per-port Avalon-ST qualifiers.
REQ-008 in_data  in  NUM_PORTS*DATA_WIDTH  per-port beat data; port i occupies slice i.
REQ-009 in_empty  in  NUM_PORTS*EMPTY_WIDTH  per-port empty; port i occupies slice i.
REQ-010 in_ready  out  NUM_PORTS  per-port ready.
REQ-011 hdr_data  in  NUM_PORTS*HEADER_SIZE  per-port header; held stable while hdr_vld[i] is high.
REQ-012 hdr_vld  in  NUM_PORTS  per-port header valid.
REQ-013 out_valid, out_sop, out_eop  out  1 each  merged stream qualifiers to the header inserter.
REQ-014 out_data  out  DATA_WIDTH; out_empty  out  EMPTY_WIDTH; out_ready  in  1.
REQ-015 out_hdr_data  out  HEADER_SIZE; out_hdr_vld  out  1  header presented to the header inserter.
REQ-016 grant  out  NUM_PORTS  one-hot owner of the output, all-zero when idle.
REQ-017 busy  out  1  high while a packet is locked.

Function
REQ-018 The FSM SHALL have two states: IDLE and LOCK.
REQ-019 Port i SHALL request when hdr_vld[i] & in_valid[i] & in_sop[i].
REQ-020 In IDLE with one or more requests, the block SHALL select the first requesting port after last_grant in ascending modulo-NUM_PORTS order, register it in grant and enter LOCK on the next edge.
REQ-021 Arbitration latency SHALL be one cycle: request at edge N, grant and busy high from edge N+1.
REQ-022 In IDLE, out_valid, out_hdr_vld, in_ready and grant SHALL be 0, and out_data/out_hdr_data SHALL be don't-care.
REQ-023 In LOCK with owner g: out_valid/sop/eop/data/empty = port g's inputs; in_ready[g] = out_ready; all other in_ready = 0; out_hdr_data = hdr_data[g]; out_hdr_vld = 1.
REQ-024 The LOCK data path SHALL be combinational, with zero added beat latency.
REQ-025 On in_valid[g] & in_ready[g] & in_eop[g], the block SHALL return to IDLE, set last_grant = g and clear grant on the next edge.
REQ-026 A single-beat packet (sop and eop together) SHALL complete in one LOCK cycle.
REQ-027 Requests arriving in the eop cycle SHALL be evaluated in the following IDLE cycle, giving exactly one bubble cycle between packets.
REQ-028 A port whose head beat lacks sop SHALL never be granted; the other ports SHALL be unaffected.
REQ-029 hdr_vld[g] falling during LOCK SHALL NOT release the lock, and out_hdr_vld SHALL remain 1.
REQ-030 With a single persistent requester, that port SHALL be regranted after every packet.

Reset
REQ-031 While rst_n = 0 at the edge: state = IDLE, grant = 0, busy = 0, last_grant = NUM_PORTS-1 (port 0 has first priority), and all outputs SHALL be 0.
REQ-032 A reset during LOCK SHALL abandon the packet immediately; in_ready SHALL be 0 from the next cycle.

Configuration
REQ-033 With HDR_ARB_PKT_CNT_EN defined, the block SHALL add output pkt_cnt (NUM_PORTS*16 bits) holding per-port accepted-eop counters that wrap at 65535 -> 0 and clear on reset.
REQ-034 With HDR_ARB_PKT_CNT_EN undefined, the pkt_cnt port and counters SHALL be absent, with no other behavioural change.

Verification
REQ-035 Reset, then port 2 requests a 3-beat packet with out_ready=1 -> grant=4'b0100 one cycle later, 3 beats forwarded, out_hdr_vld=1 throughout, IDLE after eop.
REQ-036 All 4 ports request continuously with 1-beat packets -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-037 Port 1 is locked and out_ready toggles 1,0,1 -> in_ready[1] mirrors out_ready, and no beat is lost or duplicated.
REQ-038 Port 0 presents a non-sop head while port 3 requests -> port 3 is granted, and port 0 is never granted.
REQ-039 rst_n=0 in the second beat of a 4-beat packet -> the next cycle has grant=0, in_ready=0, and port 0 has first priority afterwards.
REQ-040 With HDR_ARB_PKT_CNT_EN, 65536 packets on port 1 -> pkt_cnt[1] = 0, and the other counters = 0.
